// File: rtl/fifo_counter.sv
// Single-clock circular FIFO with an explicit occupancy counter.
// Status flags are decoded from the registered counter; read data is registered.
module fifo_counter_chk #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input logic             clk,
    input logic             rst_n,
    input logic [CNT_W-1:0] counter,
    input logic             empty,
    input logic             full
);
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        counter <= CNT_W'(DEPTH));
    a_flags_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(empty && full));
endmodule

module fifo_counter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    input  logic [WIDTH-1:0] data,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             clk,
    input  logic             rst_n
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_d;
    logic [WIDTH-1:0] data_out_d;
    logic             do_wr;
    logic             do_rd;

    assign empty = (counter == {CNT_W{1'b0}});
    assign full  = (counter == CNT_W'(DEPTH));

    // Qualify requests against pre-edge flags; an unknown request falls into the else arm.
    always_comb begin
        do_wr      = 1'b0;
        do_rd      = 1'b0;
        wr_ptr_d   = wr_ptr;
        rd_ptr_d   = rd_ptr;
        counter_d  = counter;
        data_out_d = data_out;

        if (wr_en && !full) begin
            do_wr = 1'b1;
        end else begin
            do_wr = 1'b0;
        end

        if (rd_en && !empty) begin
            do_rd = 1'b1;
        end else begin
            do_rd = 1'b0;
        end

        if (do_wr) begin
            wr_ptr_d = wr_ptr + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr;
        end

        if (do_rd) begin
            rd_ptr_d   = rd_ptr + PTR_W'(1);
            data_out_d = mem_q[rd_ptr];
        end else begin
            rd_ptr_d   = rd_ptr;
            data_out_d = data_out;
        end

        case ({do_wr, do_rd})
            2'b10:   counter_d = counter + CNT_W'(1);
            2'b01:   counter_d = counter - CNT_W'(1);
            default: counter_d = counter;
        endcase
    end

    // Control state and read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= {PTR_W{1'b0}};
            rd_ptr   <= {PTR_W{1'b0}};
            counter  <= {CNT_W{1'b0}};
            data_out <= {WIDTH{1'b0}};
        end else begin
            wr_ptr   <= wr_ptr_d;
            rd_ptr   <= rd_ptr_d;
            counter  <= counter_d;
            data_out <= data_out_d;
        end
    end

    // Storage carries no reset; an empty counter makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr] <= data;
        end
    end

    fifo_counter_chk #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .counter(counter),
        .empty  (empty),
        .full   (full)
    );
endmodule

// File: tb/tb_fifo_counter.sv
// Randomized and directed bench for fifo_counter, scored against a queue-based model.
module tb_fifo_counter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] data;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;

    fifo_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .data_out(data_out),
        .empty   (empty),
        .full    (full),
        .data    (data),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    int               m_wp;
    int               m_rp;

    logic [WIDTH-1:0] fill_tbl [0:17] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
                                          8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70,
                                          8'd80, 8'd90};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_wp   = 0;
        m_rp   = 0;
    endtask

    task automatic check_state(input string ph);
        check_eq({ph, ".data_out"}, 32'(data_out), 32'(m_dout));
        check_eq({ph, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check_eq({ph, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check_eq({ph, ".counter"}, 32'(dut.counter), 32'(q.size()));
        check_eq({ph, ".wr_ptr"}, 32'(dut.wr_ptr), 32'(m_wp));
        check_eq({ph, ".rd_ptr"}, 32'(dut.rd_ptr), 32'(m_rp));
    endtask

    task automatic step(input string ph, input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit do_wr;
        bit do_rd;
        wr_en = w;
        rd_en = r;
        data  = d;
        do_wr = w && (q.size() < DEPTH);
        do_rd = r && (q.size() != 0);
        @(posedge clk);
        if (do_rd) begin
            m_dout = q.pop_front();
            m_rp   = (m_rp + 1) % DEPTH;
        end
        if (do_wr) begin
            q.push_back(d);
            m_wp = (m_wp + 1) % DEPTH;
        end
        #1;
        check_state(ph);
    endtask

    initial begin
        logic [WIDTH-1:0] saved;
        int               pw;

        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        data  = '0;
        model_reset();
        #3;
        check_state("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step("fill", 1'b1, 1'b0, fill_tbl[i]);
            if (i == 15) begin
                check_eq("fill.full16", 32'(full), 32'd1);
                check_eq("fill.cnt16", 32'(dut.counter), 32'd16);
            end
        end
        check_eq("fill.wp_wrap", 32'(dut.wr_ptr), 32'd0);

        for (int i = 0; i < 50; i++) begin
            step("drain", 1'b0, 1'b1, 8'd0);
            if (i < 16) begin
                check_eq("drain.seq", 32'(data_out), 32'(fill_tbl[i]));
            end
            if (i == 15) begin
                check_eq("drain.empty16", 32'(empty), 32'd1);
            end
        end
        check_eq("drain.hold70", 32'(data_out), 32'd70);
        check_eq("drain.cnt0", 32'(dut.counter), 32'd0);
        check_eq("drain.rp0", 32'(dut.rd_ptr), 32'd0);

        for (int i = 0; i < 4; i++) begin
            step("preload", 1'b1, 1'b0, 8'($urandom));
        end
        for (int i = 0; i < 16; i++) begin
            step("simul", 1'b1, 1'b1, 8'($urandom));
            check_eq("simul.cnt4", 32'(dut.counter), 32'd4);
        end
        check_eq("simul.wp_wrap", 32'(dut.wr_ptr), 32'd4);
        check_eq("simul.rp_wrap", 32'(dut.rd_ptr), 32'd0);

        while (q.size() != 0) begin
            step("to_empty", 1'b0, 1'b1, 8'd0);
        end
        saved = m_dout;
        step("both_empty", 1'b1, 1'b1, 8'hA5);
        check_eq("both_empty.cnt1", 32'(dut.counter), 32'd1);
        check_eq("both_empty.dout", 32'(data_out), 32'(saved));

        for (int i = 0; i < 15; i++) begin
            step("to_full", 1'b1, 1'b0, 8'(i + 100));
        end
        check_eq("to_full.full", 32'(full), 32'd1);
        step("both_full", 1'b1, 1'b1, 8'hEE);
        check_eq("both_full.cnt15", 32'(dut.counter), 32'd15);
        for (int i = 0; i < 15; i++) begin
            step("post_full", 1'b0, 1'b1, 8'd0);
        end
        check_eq("post_full.last", 32'(data_out), 32'd114);

        pw = 80;
        for (int i = 0; i < 400; i++) begin
            if ((i % 40) == 0) begin
                pw = (pw == 80) ? 20 : 80;
            end
            step("rand", 1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) >= pw),
                 8'($urandom));
        end

        while (q.size() != 0) begin
            step("pre_ar", 1'b0, 1'b1, 8'd0);
        end
        for (int i = 0; i < 7; i++) begin
            step("pre_ar", 1'b1, 1'b0, 8'($urandom));
        end
        check_eq("pre_ar.cnt7", 32'(dut.counter), 32'd7);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("areset");
        check_eq("areset.cnt0", 32'(dut.counter), 32'd0);
        #1;
        rst_n = 1'b1;
        step("after_ar", 1'b0, 1'b1, 8'd0);
        check_eq("after_ar.empty", 32'(empty), 32'd1);
        check_eq("after_ar.dout0", 32'(data_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
